// File: rtl/pcie_rd_ram_mux.sv
// DMA read requests are queued, each fetches one word from a channel RAM and is
// serialised LSB-first into DMA beats. Optional build macro: RD_BYTE_SWAP_EN (byte-reversed beats).
module pcie_rd_ram_mux #(
    parameter int NUM_CH    = 2,
    parameter int RAM_DW    = 512,
    parameter int DMA_DW    = 64,
    parameter int RAM_AW    = 11,
    parameter int RAM_LAT   = 2,
    parameter int REQ_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dma_raddr_en,
    input  logic [31:0]              dma_raddr,
    output logic [DMA_DW-1:0]        dma_rdata,
    output logic                     dma_rdata_rdy,
    output logic                     dma_rdata_busy,
    output logic [NUM_CH*RAM_AW-1:0] ch_raddr,
    input  logic [NUM_CH*RAM_DW-1:0] ch_doutb,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_rd_done,
    output logic                     err_flag
);

    localparam int BEATS  = RAM_DW / DMA_DW;
    localparam int OFS    = $clog2(RAM_DW / 8);
    localparam int CH_LSB = RAM_AW + OFS;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = 2;
    localparam int PTR_W  = $clog2(REQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = CH_W + RAM_AW;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_SHIFT} state_t;

    function automatic logic [DMA_DW-1:0] beat_fmt(input logic [DMA_DW-1:0] d);
        logic [DMA_DW-1:0] r;
`ifdef RD_BYTE_SWAP_EN
        r = '0;
        for (int b = 0; b < DMA_DW / 8; b++) begin
            r[b*8 +: 8] = d[(DMA_DW/8 - 1 - b)*8 +: 8];
        end
`else
        r = d;
`endif
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [BC_W-1:0]          beat_q, beat_d;
    logic [RAM_DW-1:0]        shift_q, shift_d;
    logic [CH_W-1:0]          cur_ch_q, cur_ch_d;
    logic                     cur_bad_q, cur_bad_d;
    logic [ENT_W-1:0]         mem_q [REQ_DEPTH];
    logic [ENT_W-1:0]         mem_d [REQ_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     busy_q, busy_d;
    logic [NUM_CH*RAM_AW-1:0] raddr_q, raddr_d;
    logic [DMA_DW-1:0]        rdata_q, rdata_d;
    logic                     rdy_q, rdy_d;
    logic [NUM_CH-1:0]        done_pre_q, done_pre_d;
    logic [NUM_CH-1:0]        rd_done_q, rd_done_d;
    logic                     err_q, err_d;

    logic [CH_W-1:0]   req_ch_s;
    logic [RAM_AW-1:0] req_word_s;
    logic [ENT_W-1:0]  head_s;
    logic [CH_W-1:0]   pop_ch_s;
    logic [RAM_AW-1:0] pop_word_s;
    logic              full_s, empty_s, push_s, pop_s, ovf_s;
    logic [RAM_DW-1:0] sel_data_s;
    logic              sel_valid_s;
    logic              unused_addr_s;

    assign req_ch_s      = dma_raddr[CH_LSB +: CH_W];
    assign req_word_s    = dma_raddr[OFS +: RAM_AW];
    assign unused_addr_s = ^{dma_raddr[OFS-1:0], dma_raddr[31:CH_LSB+CH_W]};

    assign full_s     = (count_q == CNT_W'(REQ_DEPTH));
    assign empty_s    = (count_q == '0);
    assign push_s     = dma_raddr_en && !full_s;
    assign ovf_s      = dma_raddr_en && full_s;
    assign pop_s      = (state_q == S_IDLE) && !empty_s;
    assign head_s     = mem_q[rd_ptr_q];
    assign pop_ch_s   = head_s[ENT_W-1 -: CH_W];
    assign pop_word_s = head_s[RAM_AW-1:0];

    // Request FIFO bookkeeping: storage, pointers, occupancy and the full flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {req_ch_s, req_word_s};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        busy_d = (count_d == CNT_W'(REQ_DEPTH));
    end

    // Select the RAM read data of the active channel; out-of-range channels read as invalid.
    always_comb begin
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data_s  = (cur_ch_q == CH_W'(i)) ? ch_doutb[i*RAM_DW +: RAM_DW] : sel_data_s;
            sel_valid_s = (cur_ch_q == CH_W'(i)) ? ch_valid[i] : sel_valid_s;
        end
    end

    // Read sequencer: pop, wait out the RAM latency, capture, then shift out beats.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        shift_d    = shift_q;
        cur_ch_d   = cur_ch_q;
        cur_bad_d  = cur_bad_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        rdy_d      = 1'b0;
        done_pre_d = '0;
        rd_done_d  = done_pre_q;
        err_d      = err_q | ovf_s;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    cur_ch_d = pop_ch_s;
                    lat_d    = '0;
                    beat_d   = '0;
                    state_d  = S_ADDR;
                    for (int i = 0; i < NUM_CH; i++) begin
                        raddr_d[i*RAM_AW +: RAM_AW] = (pop_ch_s == CH_W'(i)) ?
                            pop_word_s : raddr_q[i*RAM_AW +: RAM_AW];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR, S_WAIT: begin
                if (lat_q == LAT_W'(RAM_LAT - 1)) begin
                    shift_d   = sel_valid_s ? sel_data_s : '0;
                    cur_bad_d = !sel_valid_s;
                    err_d     = err_q | ovf_s | !sel_valid_s;
                    state_d   = S_SHIFT;
                end else begin
                    lat_d   = lat_q + LAT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_SHIFT: begin
                rdy_d   = 1'b1;
                rdata_d = beat_fmt(shift_q[DMA_DW-1:0]);
                shift_d = shift_q >> DMA_DW;
                if (beat_q == BC_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = S_IDLE;
                    // Release is delayed one cycle so it follows the last beat.
                    for (int i = 0; i < NUM_CH; i++) begin
                        done_pre_d[i] = !cur_bad_q && (cur_ch_q == CH_W'(i));
                    end
                end else begin
                    beat_d = beat_q + BC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            beat_q     <= '0;
            shift_q    <= '0;
            cur_ch_q   <= '0;
            cur_bad_q  <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            raddr_q    <= '0;
            rdata_q    <= '0;
            rdy_q      <= 1'b0;
            done_pre_q <= '0;
            rd_done_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            cur_ch_q   <= cur_ch_d;
            cur_bad_q  <= cur_bad_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            rdy_q      <= rdy_d;
            done_pre_q <= done_pre_d;
            rd_done_q  <= rd_done_d;
            err_q      <= err_d;
        end
    end

    assign dma_rdata      = rdata_q;
    assign dma_rdata_rdy  = rdy_q;
    assign dma_rdata_busy = busy_q;
    assign ch_raddr       = raddr_q;
    assign ch_rd_done     = rd_done_q;
    assign err_flag       = err_q;

endmodule

// File: tb/tb_pcie_rd_ram_mux.sv
// Directed bench for pcie_rd_ram_mux with default parameters (2 channels, 8 beats per word).
module tb_pcie_rd_ram_mux;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [31:0]   addr;
    logic [63:0]   dma_rdata;
    logic          dma_rdata_rdy;
    logic          dma_rdata_busy;
    logic [21:0]   ch_raddr;
    logic [1023:0] ch_doutb;
    logic [1:0]    ch_valid;
    logic [1:0]    ch_rd_done;
    logic          err_flag;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc_n    = 0;
    int done0_cnt, done1_cnt, done0_cyc, busy_cnt;
    logic [63:0] beats[$];
    int          beat_cyc[$];

    pcie_rd_ram_mux dut (
        .clk(clk), .rst(rst), .dma_raddr_en(en), .dma_raddr(addr),
        .dma_rdata(dma_rdata), .dma_rdata_rdy(dma_rdata_rdy), .dma_rdata_busy(dma_rdata_busy),
        .ch_raddr(ch_raddr), .ch_doutb(ch_doutb), .ch_valid(ch_valid),
        .ch_rd_done(ch_rd_done), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_beat(input logic [63:0] d);
        logic [63:0] r;
`ifdef RD_BYTE_SWAP_EN
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = d[(7-b)*8 +: 8];
`else
        r = d;
`endif
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc_n++;
        if (dma_rdata_rdy === 1'b1) begin
            beats.push_back(dma_rdata);
            beat_cyc.push_back(cyc_n);
        end
        if (ch_rd_done[0] === 1'b1) begin
            done0_cnt++;
            done0_cyc = cyc_n;
        end
        if (ch_rd_done[1] === 1'b1) done1_cnt++;
        if (dma_rdata_busy === 1'b1) busy_cnt++;
    endtask

    task automatic clear_mon();
        beats.delete();
        beat_cyc.delete();
        done0_cnt = 0;
        done1_cnt = 0;
        done0_cyc = 0;
        busy_cnt  = 0;
    endtask

    task automatic issue(input logic [31:0] a);
        en   = 1'b1;
        addr = a;
        step();
        en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        addr = 32'h0;
        repeat (3) step();
        chk_cnt++; if (dma_rdata_rdy !== 1'b0) $display("FAIL reset_rdy: got %0h expected 0", dma_rdata_rdy); else pass_cnt++;
        chk_cnt++; if (dma_rdata !== 64'h0) $display("FAIL reset_rdata: got %0h expected 0", dma_rdata); else pass_cnt++;
        chk_cnt++; if (dma_rdata_busy !== 1'b0) $display("FAIL reset_busy: got %0h expected 0", dma_rdata_busy); else pass_cnt++;
        chk_cnt++; if (ch_raddr !== 22'h0) $display("FAIL reset_raddr: got %0h expected 0", ch_raddr); else pass_cnt++;
        chk_cnt++; if (ch_rd_done !== 2'b00) $display("FAIL reset_done: got %0h expected 0", ch_rd_done); else pass_cnt++;
        chk_cnt++; if (err_flag !== 1'b0) $display("FAIL reset_err: got %0h expected 0", err_flag); else pass_cnt++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int k;
        clear_mon();
        k = cyc_n;
        issue(32'h40);
        repeat (24) step();
        chk_cnt++; if (ch_raddr[10:0] !== 11'd1) $display("FAIL single_raddr: got %0h expected 1", ch_raddr[10:0]); else pass_cnt++;
        chk_cnt++; if (beats.size() !== 8) $display("FAIL single_nbeats: got %0d expected 8", beats.size()); else pass_cnt++;
        chk_cnt++; if (beat_cyc[0] !== k + 5) $display("FAIL single_latency: got %0d expected %0d", beat_cyc[0], k + 5); else pass_cnt++;
        chk_cnt++; if (beat_cyc[7] !== k + 12) $display("FAIL single_consec: got %0d expected %0d", beat_cyc[7], k + 12); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (beats[i] !== exp_beat(64'h1234567812345678))
                $display("FAIL single_beat%0d: got %0h expected %0h", i, beats[i], exp_beat(64'h1234567812345678));
            else pass_cnt++;
        end
        chk_cnt++; if (done0_cnt !== 1) $display("FAIL single_done0: got %0d expected 1", done0_cnt); else pass_cnt++;
        chk_cnt++; if (done0_cyc !== k + 13) $display("FAIL single_done_time: got %0d expected %0d", done0_cyc, k + 13); else pass_cnt++;
        chk_cnt++; if (done1_cnt !== 0) $display("FAIL single_done1: got %0d expected 0", done1_cnt); else pass_cnt++;
        chk_cnt++; if (err_flag !== 1'b0) $display("FAIL single_err: got %0h expected 0", err_flag); else pass_cnt++;
        chk_cnt++; if (dma_rdata !== exp_beat(64'h1234567812345678)) $display("FAIL single_hold: got %0h expected %0h", dma_rdata, exp_beat(64'h1234567812345678)); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int k;
        clear_mon();
        k = cyc_n;
        en = 1'b1; addr = 32'h40;
        step();
        addr = 32'h80;
        step();
        en = 1'b0;
        repeat (30) step();
        chk_cnt++; if (beats.size() !== 16) $display("FAIL b2b_nbeats: got %0d expected 16", beats.size()); else pass_cnt++;
        chk_cnt++; if (beat_cyc[0] !== k + 5) $display("FAIL b2b_first: got %0d expected %0d", beat_cyc[0], k + 5); else pass_cnt++;
        chk_cnt++; if (beat_cyc[8] !== k + 16) $display("FAIL b2b_second: got %0d expected %0d", beat_cyc[8], k + 16); else pass_cnt++;
        chk_cnt++; if (beat_cyc[15] !== k + 23) $display("FAIL b2b_last: got %0d expected %0d", beat_cyc[15], k + 23); else pass_cnt++;
        chk_cnt++; if (ch_raddr[10:0] !== 11'd2) $display("FAIL b2b_raddr: got %0h expected 2", ch_raddr[10:0]); else pass_cnt++;
        chk_cnt++; if (busy_cnt !== 0) $display("FAIL b2b_busy: got %0d expected 0", busy_cnt); else pass_cnt++;
        chk_cnt++; if (done0_cnt !== 2) $display("FAIL b2b_done0: got %0d expected 2", done0_cnt); else pass_cnt++;
    endtask

    task automatic test_channel1();
        logic [63:0] e;
        clear_mon();
        issue(32'h20040);
        repeat (24) step();
        chk_cnt++; if (ch_raddr[21:11] !== 11'd1) $display("FAIL ch1_raddr: got %0h expected 1", ch_raddr[21:11]); else pass_cnt++;
        chk_cnt++; if (ch_raddr[10:0] !== 11'd2) $display("FAIL ch1_raddr0_hold: got %0h expected 2", ch_raddr[10:0]); else pass_cnt++;
        chk_cnt++; if (beats.size() !== 8) $display("FAIL ch1_nbeats: got %0d expected 8", beats.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            e = exp_beat(64'hC0DE_0000_0000_0000 + 64'(i));
            chk_cnt++;
            if (beats[i] !== e) $display("FAIL ch1_beat%0d: got %0h expected %0h", i, beats[i], e);
            else pass_cnt++;
        end
        chk_cnt++; if (done1_cnt !== 1) $display("FAIL ch1_done1: got %0d expected 1", done1_cnt); else pass_cnt++;
        chk_cnt++; if (done0_cnt !== 0) $display("FAIL ch1_done0: got %0d expected 0", done0_cnt); else pass_cnt++;
    endtask

    task automatic test_invalid();
        clear_mon();
        ch_valid = 2'b10;
        issue(32'h40);
        repeat (24) step();
        ch_valid = 2'b11;
        chk_cnt++; if (beats.size() !== 8) $display("FAIL inv_nbeats: got %0d expected 8", beats.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (beats[i] !== 64'h0) $display("FAIL inv_beat%0d: got %0h expected 0", i, beats[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (err_flag !== 1'b1) $display("FAIL inv_err: got %0h expected 1", err_flag); else pass_cnt++;
        chk_cnt++; if (done0_cnt !== 0) $display("FAIL inv_done0: got %0d expected 0", done0_cnt); else pass_cnt++;
    endtask

    task automatic test_overflow();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk_cnt++; if (err_flag !== 1'b0) $display("FAIL ovf_err_cleared: got %0h expected 0", err_flag); else pass_cnt++;
        clear_mon();
        en = 1'b1; addr = 32'h40;
        repeat (6) step();
        en = 1'b0;
        chk_cnt++; if (dma_rdata_busy !== 1'b1) $display("FAIL ovf_busy: got %0h expected 1", dma_rdata_busy); else pass_cnt++;
        chk_cnt++; if (err_flag !== 1'b1) $display("FAIL ovf_err: got %0h expected 1", err_flag); else pass_cnt++;
        repeat (70) step();
        chk_cnt++; if (busy_cnt !== 8) $display("FAIL ovf_busy_cycles: got %0d expected 8", busy_cnt); else pass_cnt++;
        chk_cnt++; if (beats.size() !== 40) $display("FAIL ovf_nbeats: got %0d expected 40", beats.size()); else pass_cnt++;
        chk_cnt++; if (done0_cnt !== 5) $display("FAIL ovf_done0: got %0d expected 5", done0_cnt); else pass_cnt++;
        chk_cnt++; if (dma_rdata_busy !== 1'b0) $display("FAIL ovf_busy_end: got %0h expected 0", dma_rdata_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        clear_mon();
        en = 1'b1; addr = 32'h40;
        repeat (5) step();
        en = 1'b0;
        for (int i = 0; i < 20 && beats.size() < 4; i++) step();
        chk_cnt++; if (beats.size() !== 4) $display("FAIL mid_reach_beat3: got %0d expected 4", beats.size()); else pass_cnt++;
        chk_cnt++; if (dma_rdata_busy !== 1'b1) $display("FAIL mid_busy_before: got %0h expected 1", dma_rdata_busy); else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++; if (dma_rdata_rdy !== 1'b0) $display("FAIL mid_rdy: got %0h expected 0", dma_rdata_rdy); else pass_cnt++;
        chk_cnt++; if (dma_rdata !== 64'h0) $display("FAIL mid_rdata: got %0h expected 0", dma_rdata); else pass_cnt++;
        chk_cnt++; if (dma_rdata_busy !== 1'b0) $display("FAIL mid_busy: got %0h expected 0", dma_rdata_busy); else pass_cnt++;
        rst = 1'b1;
        repeat (30) step();
        chk_cnt++; if (beats.size() !== 4) $display("FAIL mid_no_more_beats: got %0d expected 4", beats.size()); else pass_cnt++;
        chk_cnt++; if (done0_cnt !== 0) $display("FAIL mid_no_done: got %0d expected 0", done0_cnt); else pass_cnt++;
    endtask

    initial begin
        ch_doutb = '0;
        ch_doutb[511:0] = {16{32'h12345678}};
        for (int i = 0; i < 8; i++) ch_doutb[512 + i*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(i);
        ch_valid = 2'b11;
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_channel1();
        test_invalid();
        test_overflow();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pcie_rd_ram_mux.md
Name: pcie_rd_ram_mux

Overview:
Parametrised successor to the single-pair PCIe DMA read engine. Accepts DMA read requests (byte address + strobe) from the PCIe DMA controller and queues them in a small request FIFO. Each request selects one of NUM_CH channel buffer RAMs, reads one RAM_DW-wide word and serialises it into DMA_DW-wide beats. Sits between the PCIe DMA read path and the per-channel TS/OTT buffer RAMs. Pulses a per-channel release signal when a word has been fully delivered.

Parameters:
NUM_CH, 2, number of channel RAMs (1..8)
RAM_DW, 512, RAM read data width; must be an integer multiple of DMA_DW
DMA_DW, 64, DMA data beat width
RAM_AW, 11, per-channel RAM word address width
RAM_LAT, 2, RAM read latency in cycles from address to valid data (1..4)
REQ_DEPTH, 4, request FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
dma_raddr_en  in  1  request strobe, one request per high cycle
dma_raddr  in  32  request byte address
dma_rdata  out  DMA_DW  serialised read data
dma_rdata_rdy  out  1  dma_rdata valid this cycle
dma_rdata_busy  out  1  request FIFO full
ch_raddr  out  NUM_CH*RAM_AW  per-channel RAM address, channel i at [i*RAM_AW +: RAM_AW]
ch_doutb  in  NUM_CH*RAM_DW  per-channel RAM read data
ch_valid  in  NUM_CH  channel RAM holds valid content
ch_rd_done  out  NUM_CH  one-cycle pulse after the last beat of a word from channel i
err_flag  out  1  sticky error flag

Behaviour:
- Address decode, with BEATS=RAM_DW/DMA_DW, OFS=log2(RAM_DW/8), CH_LSB=RAM_AW+OFS, CH_W=max(1,clog2(NUM_CH)):
  - word = dma_raddr[OFS +: RAM_AW]
  - channel = dma_raddr[CH_LSB +: CH_W]
  - byte-offset bits below OFS are ignored.
- Reset (rst==0 at a clk edge):
  - All outputs go to 0 and ch_raddr goes to 0.
  - The FIFO is flushed and the FSM enters IDLE.
  - Reset takes effect mid-burst as well; no further beats are emitted for the aborted word.
- Request FIFO:
  - When dma_raddr_en=1 and the FIFO is not full, {channel, word} is pushed.
  - When dma_raddr_en=1 and the FIFO is full, the request is dropped and err_flag is set.
  - dma_rdata_busy is registered and is high while count==REQ_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
- FSM states IDLE, ADDR, WAIT, SHIFT:
  - IDLE: if the FIFO is non-empty, pop it, drive ch_raddr[ch]=word (other channels hold their last value), and go to ADDR.
  - ADDR/WAIT: count RAM_LAT cycles, then capture ch_doutb[ch] into the shift register and go to SHIFT.
  - Invalid channel (channel>=NUM_CH, or ch_valid[ch]=0 at capture): capture zeros and set err_flag.
  - SHIFT: emit BEATS beats on consecutive cycles with dma_rdata_rdy=1.
  - Beat order is LSB first: beat k = word[k*DMA_DW +: DMA_DW].
  - On the cycle after the last beat, pulse ch_rd_done[ch] (not pulsed for invalid requests) and return to IDLE.
  - IDLE may pop the next request in that same cycle.
- Throughput: one word per 1+RAM_LAT+BEATS cycles.
- Latency: first beat appears RAM_LAT+2 cycles after the push edge.
- dma_rdata holds its last value when rdy=0; it is 0 after reset.
- err_flag is cleared only by reset.
- Beat counter width is clog2(BEATS); no wrap beyond BEATS-1.

Optional Feature:
Macro RD_BYTE_SWAP_EN.
- Defined: each emitted beat is byte-reversed (byte 0 ↔ byte DMA_DW/8-1) for host little-endian view.
- Undefined: beats pass unmodified.
- Timing and handshakes are identical in both cases.

Test Plan:
- Reset active, release, ch_doutb[0]=0x12345678 repeated, ch_valid=2'b11, single request 0x40 -> ch_raddr[10:0]=1; 8 beats of 0x1234567812345678 with rdy high for 8 consecutive cycles; ch_rd_done[0] pulses once; err_flag=0.
- Back-to-back requests 0x40 then 0x80 on consecutive cycles -> two 8-beat bursts separated by 1+RAM_LAT idle cycles; second burst uses ch_raddr[10:0]=2; no busy.
- Request 0x20040 -> channel 1, ch_raddr[21:11]=1, beats taken from ch_doutb[1023:512], ch_rd_done[1] pulses.
- ch_valid[0]=0, request 0x40 -> 8 beats of 0x0; err_flag goes to 1; no ch_rd_done pulse.
- Six consecutive request cycles with REQ_DEPTH=4 -> busy asserted after the FIFO fills; overflowing requests are dropped; err_flag=1; exactly the accepted number of bursts are emitted.
- Reset asserted during beat 3 -> next cycle rdy=0, dma_rdata=0, busy=0; no further beats or ch_rd_done.
